// File: rtl/acq_search_ctrl_pkg.sv
// Shared widths, state encoding and helpers for the acquisition search controller.
package acq_search_ctrl_pkg;

  localparam int I2Q2_W             = 32;
  localparam int DOPPLER_W          = 32;
  localparam int CS_W               = 11;
  localparam int PRN_W              = 5;
  localparam int ACQ_MAX_BINS       = 64;
  localparam int ACQ_TIMEOUT_CYCLES = 16777216;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } acq_state_e;

  // Strictly greater wins so that equal peaks keep the earlier bin.
  function automatic logic peak_better(input logic [I2Q2_W-1:0] cand,
                                       input logic [I2Q2_W-1:0] best);
    return (cand > best);
  endfunction

endpackage

// File: rtl/acq_peak_tracker.sv
// Holds the strongest correlation peak seen so far in a Doppler sweep.
module acq_peak_tracker
  import acq_search_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic [I2Q2_W-1:0]    peak_i2q2,
  input  logic [DOPPLER_W-1:0] peak_doppler,
  input  logic [CS_W-1:0]      peak_code_shift,
  output logic [I2Q2_W-1:0]    best_i2q2,
  output logic [DOPPLER_W-1:0] best_doppler,
  output logic [CS_W-1:0]      best_code_shift,
  output logic [I2Q2_W-1:0]    next_i2q2
);

  logic take_s;

  // Capture decision and the best value as it will be after this cycle.
  always_comb begin
    take_s    = load && peak_better(peak_i2q2, best_i2q2);
    next_i2q2 = take_s ? peak_i2q2 : best_i2q2;
  end

  // Best-peak registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_i2q2       <= '0;
      best_doppler    <= '0;
      best_code_shift <= '0;
    end else if (clear) begin
      best_i2q2       <= '0;
      best_doppler    <= '0;
      best_code_shift <= '0;
    end else if (take_s) begin
      best_i2q2       <= peak_i2q2;
      best_doppler    <= peak_doppler;
      best_code_shift <= peak_code_shift;
    end
  end

endmodule

// File: rtl/acq_search_ctrl.sv
// Sequences a Doppler bin sweep for one PRN, restarting the channel per bin
// and reporting the strongest peak found.
module acq_search_ctrl
  import acq_search_ctrl_pkg::*;
#(
  parameter int  MAX_BINS       = ACQ_MAX_BINS,
  parameter int  TIMEOUT_CYCLES = ACQ_TIMEOUT_CYCLES,
  localparam int BW             = $clog2(MAX_BINS + 1)
) (
  input  logic                 clk,
  input  logic                 global_reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PRN_W-1:0]     prn_in,
  input  logic [DOPPLER_W-1:0] doppler_start,
  input  logic [DOPPLER_W-1:0] doppler_step,
  input  logic [BW-1:0]        num_bins,
  input  logic [I2Q2_W-1:0]    threshold,
  input  logic                 acquisition_complete,
  input  logic [I2Q2_W-1:0]    acq_peak_i2q2,
  input  logic [DOPPLER_W-1:0] acq_peak_doppler,
  input  logic [CS_W-1:0]      acq_peak_code_shift,
  output logic [DOPPLER_W-1:0] doppler,
  output logic [PRN_W-1:0]     prn,
  output logic                 bin_restart,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic                 timeout,
  output logic [I2Q2_W-1:0]    best_i2q2,
  output logic [DOPPLER_W-1:0] best_doppler,
  output logic [CS_W-1:0]      best_code_shift,
  output logic [BW-1:0]        bin_index
);

  localparam int            TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] MAX_BINS_V = BW'(MAX_BINS);
  localparam logic [BW-1:0] BIN_ONE    = BW'(1'b1);

  acq_state_e            state_r, state_nx_s;
  logic [TW-1:0]         to_cnt_r;
  logic [BW-1:0]         num_bins_r, bin_index_r, nb_clamp_s;
  logic [DOPPLER_W-1:0]  doppler_r, doppler_step_r;
  logic [PRN_W-1:0]      prn_r;
  logic [I2Q2_W-1:0]     threshold_r, next_i2q2_s;
  logic                  bin_restart_r, busy_r, done_r, found_r, timeout_r;
  logic                  start_accept_s, abort_s, last_bin_s, to_hit_s;
  logic                  load_s, step_s;

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_nx_s     = state_r;
    start_accept_s = 1'b0;
    to_hit_s       = 1'b0;
    nb_clamp_s     = (num_bins > MAX_BINS_V) ? MAX_BINS_V : num_bins;
    abort_s        = abort && (state_r != ST_IDLE);
    last_bin_s     = ((bin_index_r + BIN_ONE) == num_bins_r);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          start_accept_s = 1'b1;
          state_nx_s     = (nb_clamp_s == '0) ? ST_DONE : ST_ARM;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        state_nx_s = abort_s ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (abort_s) begin
          state_nx_s = ST_IDLE;
        end else if (acquisition_complete) begin
          state_nx_s = ST_UPDATE;
        end else if (to_cnt_r == TO_LAST) begin
          to_hit_s   = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_UPDATE: begin
        if (abort_s) begin
          state_nx_s = ST_IDLE;
        end else if (last_bin_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_ARM;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
    load_s = (state_r == ST_UPDATE) && !abort_s;
    step_s = load_s && !last_bin_s;
  end

  // State register.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Per-bin timeout counter; runs only while waiting on the channel.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      to_cnt_r <= '0;
    end else if (state_r == ST_ARM) begin
      to_cnt_r <= '0;
    end else if (state_r == ST_WAIT) begin
      to_cnt_r <= to_cnt_r + TW'(1'b1);
    end
  end

  // Latched configuration and the running bin / Doppler position.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      prn_r          <= '0;
      doppler_r      <= '0;
      doppler_step_r <= '0;
      threshold_r    <= '0;
      num_bins_r     <= '0;
      bin_index_r    <= '0;
    end else if (start_accept_s) begin
      prn_r          <= prn_in;
      doppler_r      <= doppler_start;
      doppler_step_r <= doppler_step;
      threshold_r    <= threshold;
      num_bins_r     <= nb_clamp_s;
      bin_index_r    <= '0;
    end else if (step_s) begin
      bin_index_r    <= bin_index_r + BIN_ONE;
      doppler_r      <= doppler_r + doppler_step_r;
    end
  end

  // Outcome flags; found uses the post-update best so the last bin counts.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      found_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else if (start_accept_s || abort_s) begin
      found_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else if (load_s && last_bin_s) begin
      found_r   <= (next_i2q2_s >= threshold_r);
    end else if (to_hit_s) begin
      found_r   <= 1'b0;
      timeout_r <= 1'b1;
    end
  end

  // Status strobes, registered to line up with the state they describe.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      bin_restart_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      bin_restart_r <= (state_r == ST_ARM) && !abort_s;
      busy_r        <= (state_nx_s == ST_ARM) || (state_nx_s == ST_WAIT) ||
                       (state_nx_s == ST_UPDATE);
      done_r        <= (state_nx_s == ST_DONE);
    end
  end

  acq_peak_tracker u_peak (
    .clk             (clk),
    .rst             (global_reset),
    .clear           (start_accept_s),
    .load            (load_s),
    .peak_i2q2       (acq_peak_i2q2),
    .peak_doppler    (acq_peak_doppler),
    .peak_code_shift (acq_peak_code_shift),
    .best_i2q2       (best_i2q2),
    .best_doppler    (best_doppler),
    .best_code_shift (best_code_shift),
    .next_i2q2       (next_i2q2_s)
  );

  assign doppler     = doppler_r;
  assign prn         = prn_r;
  assign bin_index   = bin_index_r;
  assign bin_restart = bin_restart_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign found       = found_r;
  assign timeout     = timeout_r;

endmodule
